// File: rtl/pid_ctrl_gen2_if.sv
// Sample/command bundle between the inertial interface (master) and the balance PID (slave).
interface pid_ctrl_gen2_if #(
    parameter int unsigned OUT_W = 12
);
    logic                    pwr_up;
    logic                    rider_off;
    logic                    vld;
    logic signed [15:0]      ptch;
    logic signed [15:0]      ptch_rt;
    logic signed [OUT_W-1:0] PID_cntrl;
    logic                    pid_vld;
    logic [7:0]              ss_tmr;
    logic                    int_sat;

    modport master (
        output pwr_up, rider_off, vld, ptch, ptch_rt,
        input  PID_cntrl, pid_vld, ss_tmr, int_sat
    );

    modport slave (
        input  pwr_up, rider_off, vld, ptch, ptch_rt,
        output PID_cntrl, pid_vld, ss_tmr, int_sat
    );
endinterface

// File: rtl/pid_ctrl_gen2.sv
// Two-stage balance PID: saturated error, anti-windup integrator, selectable D term,
// saturated registered output with optional soft-start scaling.
module pid_ctrl_gen2 #(
    parameter int unsigned ERR_W    = 10,
    parameter int unsigned OUT_W    = 12,
    parameter int unsigned INT_W    = 18,
    parameter int          P_COEFF  = 13,
    parameter int unsigned I_SHIFT  = 6,
    parameter int unsigned D_MODE   = 0,
    parameter int unsigned D_SHIFT  = 6,
    parameter int          D_COEFF  = 4,
    parameter bit          INT_SAT  = 1'b1,
    parameter int unsigned SS_W     = 27,
    parameter bit          SS_SCALE = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    pid_ctrl_gen2_if.slave bus
);
    // Wide enough that no P/I/D combination can wrap before output saturation.
    localparam int unsigned SUM_W     = 64;
    localparam int          ERR_MAX_I = 2 ** (ERR_W - 1) - 1;
    localparam int          ERR_MIN_I = -(2 ** (ERR_W - 1));
    localparam int          OUT_MAX_I = 2 ** (OUT_W - 1) - 1;
    localparam int          OUT_MIN_I = -(2 ** (OUT_W - 1));
    localparam logic signed [INT_W-1:0] IntMax = {1'b0, {(INT_W - 1){1'b1}}};
    localparam logic signed [INT_W-1:0] IntMin = {1'b1, {(INT_W - 1){1'b0}}};

    logic signed [ERR_W-1:0] err, err_q, prev_err_q;
    logic signed [INT_W-1:0] integ_q, integ_d;
    logic signed [INT_W:0]   integ_sum;
    logic                    ovf, ovf_set;
    logic signed [SUM_W-1:0] d_q, d_d;
    logic signed [SUM_W-1:0] p_term, i_term, sum, prod;
    logic signed [OUT_W-1:0] sat, pid_q, pid_d;
    logic                    stage2_q, pid_vld_q, int_sat_q;
    logic [SS_W-1:0]         ss_cnt_q;
    logic [7:0]              ss_tmr;

    assign ss_tmr = ss_cnt_q[SS_W-1 -: 8];

    always_comb begin
        if (32'(bus.ptch) > ERR_MAX_I) begin
            err = ERR_W'(ERR_MAX_I);
        end else if (32'(bus.ptch) < ERR_MIN_I) begin
            err = ERR_W'(ERR_MIN_I);
        end else begin
            err = bus.ptch[ERR_W-1:0];
        end
    end

    always_comb begin
        integ_sum = {integ_q[INT_W-1], integ_q} + (INT_W + 1)'(err);
        ovf       = integ_sum[INT_W] ^ integ_sum[INT_W-1];
        ovf_set   = ovf & INT_SAT;
        integ_d   = integ_sum[INT_W-1:0];
        if (ovf) begin
            if (INT_SAT) begin
                integ_d = integ_sum[INT_W] ? IntMin : IntMax;
            end else begin
                integ_d = integ_q;
            end
        end
    end

    // D is formed in stage 1 so stage 2 only needs the registered term.
    always_comb begin
        if (D_MODE == 1) begin
            d_d = -((SUM_W'(err) - SUM_W'(prev_err_q)) * SUM_W'(D_COEFF));
        end else begin
            d_d = -(SUM_W'(bus.ptch_rt) >>> D_SHIFT);
        end
    end

    always_comb begin
        p_term = SUM_W'(P_COEFF) * SUM_W'(err_q);
        i_term = SUM_W'(integ_q) >>> I_SHIFT;
        sum    = p_term + i_term + d_q;
        if (sum > SUM_W'(OUT_MAX_I)) begin
            sat = OUT_W'(OUT_MAX_I);
        end else if (sum < SUM_W'(OUT_MIN_I)) begin
            sat = OUT_W'(OUT_MIN_I);
        end else begin
            sat = sum[OUT_W-1:0];
        end
        prod  = SUM_W'(sat) * SUM_W'($signed({1'b0, ss_tmr}));
        pid_d = sat;
        if (SS_SCALE && (ss_tmr != 8'hFF)) begin
            pid_d = OUT_W'(prod >>> 8);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q      <= '0;
            prev_err_q <= '0;
            integ_q    <= '0;
            d_q        <= '0;
            stage2_q   <= 1'b0;
            pid_q      <= '0;
            pid_vld_q  <= 1'b0;
            int_sat_q  <= 1'b0;
            ss_cnt_q   <= '0;
        end else begin
            if (!bus.pwr_up) begin
                ss_cnt_q <= '0;
            end else if (ss_tmr != 8'hFF) begin
                ss_cnt_q <= ss_cnt_q + 1'b1;
            end

            stage2_q  <= bus.vld;
            pid_vld_q <= stage2_q;
            if (stage2_q) begin
                pid_q <= pid_d;
            end

            if (bus.vld || bus.rider_off) begin
                err_q <= err;
            end
            if (bus.vld) begin
                d_q <= d_d;
            end

            if (bus.rider_off) begin
                integ_q    <= '0;
                prev_err_q <= '0;
                int_sat_q  <= 1'b0;
            end else if (bus.vld) begin
                integ_q    <= integ_d;
                prev_err_q <= err;
                if (ovf_set) begin
                    int_sat_q <= 1'b1;
                end
            end
        end
    end

    assign bus.PID_cntrl = pid_q;
    assign bus.pid_vld   = pid_vld_q;
    assign bus.ss_tmr    = ss_tmr;
    assign bus.int_sat   = int_sat_q;
endmodule

// File: tb/tb_pid_ctrl_gen2.sv
// Directed bench for pid_ctrl_gen2: four parameter variants share one stimulus stream.
module tb_pid_ctrl_gen2;
    logic clk = 1'b0;
    logic rst;
    logic pwr_up, rider_off, vld;
    logic signed [15:0] ptch, ptch_rt;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pid_ctrl_gen2_if #(.OUT_W(12)) if0 ();
    pid_ctrl_gen2_if #(.OUT_W(12)) if1 ();
    pid_ctrl_gen2_if #(.OUT_W(12)) if2 ();
    pid_ctrl_gen2_if #(.OUT_W(12)) if3 ();

    assign if0.pwr_up = pwr_up;  assign if0.rider_off = rider_off;  assign if0.vld = vld;
    assign if0.ptch   = ptch;    assign if0.ptch_rt   = ptch_rt;
    assign if1.pwr_up = pwr_up;  assign if1.rider_off = rider_off;  assign if1.vld = vld;
    assign if1.ptch   = ptch;    assign if1.ptch_rt   = ptch_rt;
    assign if2.pwr_up = pwr_up;  assign if2.rider_off = rider_off;  assign if2.vld = vld;
    assign if2.ptch   = ptch;    assign if2.ptch_rt   = ptch_rt;
    assign if3.pwr_up = pwr_up;  assign if3.rider_off = rider_off;  assign if3.vld = vld;
    assign if3.ptch   = ptch;    assign if3.ptch_rt   = ptch_rt;

    pid_ctrl_gen2 u0 (.clk(clk), .rst(rst), .bus(if0));
    pid_ctrl_gen2 #(.INT_SAT(1'b0)) u1 (.clk(clk), .rst(rst), .bus(if1));
    pid_ctrl_gen2 #(.SS_W(10), .SS_SCALE(1'b1)) u2 (.clk(clk), .rst(rst), .bus(if2));
    pid_ctrl_gen2 #(.D_MODE(1)) u3 (.clk(clk), .rst(rst), .bus(if3));

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // One vld cycle; returns just after the sampling edge.
    task automatic pulse(input logic signed [15:0] p, input logic ro);
        ptch      = p;
        vld       = 1'b1;
        rider_off = ro;
        tick();
        vld       = 1'b0;
        rider_off = 1'b0;
    endtask

    initial begin
        int waited;
        rst = 1'b1; pwr_up = 1'b0; rider_off = 1'b0; vld = 1'b0;
        ptch = '0; ptch_rt = '0;
        repeat (3) tick();
        chk("rst_pid", if0.PID_cntrl, 0);
        chk("rst_pid_vld", if0.pid_vld, 0);
        chk("rst_int_sat", if0.int_sat, 0);
        chk("rst_ss_tmr", if2.ss_tmr, 0);
        chk("rst_integ", u0.integ_q, 0);

        rst = 1'b0;
        pwr_up = 1'b1;
        waited = 0;
        while (if2.ss_tmr != 8'd128 && waited < 2000) begin
            tick();
            waited++;
        end
        chk("ss_reach_128", if2.ss_tmr, 128);

        pulse(16'sd16, 1'b0);
        chk("lat_not_yet", if0.pid_vld, 0);
        tick();
        chk("p16_pid", if0.PID_cntrl, 208);
        chk("p16_vld", if0.pid_vld, 1);
        chk("p16_integ", u0.integ_q, 16);
        chk("p16_hold_mode", if1.PID_cntrl, 208);
        chk("p16_ss_scaled", if2.PID_cntrl, 104);
        chk("p16_dmode1", if3.PID_cntrl, 144);
        tick();
        chk("p16_vld_drop", if0.pid_vld, 0);
        chk("p16_pid_hold", if0.PID_cntrl, 208);

        ptch = 16'sh7000; vld = 1'b1;
        tick();
        ptch = 16'sh8000;
        tick();
        vld = 1'b0;
        chk("b2b_pos_sat", if0.PID_cntrl, 2047);
        chk("b2b_vld1", if0.pid_vld, 1);
        tick();
        chk("b2b_neg_sat", if0.PID_cntrl, -2048);
        chk("b2b_vld2", if0.pid_vld, 1);
        tick();
        chk("b2b_vld_drop", if0.pid_vld, 0);

        ptch_rt = 16'sh0400;
        pulse(16'sd0, 1'b0);
        tick();
        ptch_rt = '0;
        chk("d_rate", if0.PID_cntrl, -16);
        chk("d_err_diff", if3.PID_cntrl, -2048);

        pulse(16'sd100, 1'b1);
        tick();
        chk("rider_pid", if0.PID_cntrl, 1300);
        chk("rider_integ", u0.integ_q, 0);

        ptch = 16'sh7FFF; vld = 1'b1;
        repeat (257) tick();
        vld = 1'b0;
        tick();
        chk("clamp_integ", u0.integ_q, 131071);
        chk("clamp_flag", if0.int_sat, 1);
        chk("hold_integ", u1.integ_q, 130816);
        chk("clamp_pid", if0.PID_cntrl, 2047);

        pulse(16'sd100, 1'b1);
        tick();
        chk("rider2_flag", if0.int_sat, 0);
        chk("rider2_integ", u0.integ_q, 0);
        chk("rider2_pid", if0.PID_cntrl, 1300);

        ptch_rt = 16'sh8000;
        pulse(16'sd0, 1'b0);
        tick();
        ptch_rt = '0;
        chk("d_neg_min", if0.PID_cntrl, 512);
        chk("d1_after_rider", if3.PID_cntrl, 0);

        pwr_up = 1'b0;
        tick();
        chk("ss_clear", if2.ss_tmr, 0);
        pwr_up = 1'b1;
        repeat (1019) tick();
        chk("ss_1019", if2.ss_tmr, 254);
        tick();
        chk("ss_1020", if2.ss_tmr, 255);
        repeat (20) tick();
        chk("ss_freeze", if2.ss_tmr, 255);

        pulse(16'sd16, 1'b0);
        tick();
        chk("ss_done_unscaled", if2.PID_cntrl, 208);

        pulse(16'sd16, 1'b0);
        rst = 1'b1;
        tick();
        chk("rst_mid_vld", if0.pid_vld, 0);
        chk("rst_mid_pid", if0.PID_cntrl, 0);
        rst = 1'b0;
        tick();
        chk("rst_mid_no_vld", if0.pid_vld, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
